// File: rtl/mem_pkg.sv
// Shared memory-element definitions: arbiter state encoding and bank geometry.
// Imported by the bank arbiter, its round-robin picker and the bank/predecoder.
package mem_pkg;

   localparam int BANK_ADDR_WIDTH = 4;
   localparam int BANK_WORDS      = 16;
   localparam int CNT_WIDTH       = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Width of a binary requester index; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_bank_arbiter_rr_pick.sv
// Combinational round-robin priority selector.
// Scans from last_grant+1 upward with wrap; reusable for any shared resource.
module rr_pick
   import mem_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  winner,
   output logic [IW-1:0] index,
   output logic          any_req
);

   logic          found;
   logic [IW-1:0] j;

   assign any_req = |req;

   // First requester after the previous winner, wrapping modulo N.
   always_comb begin
      winner = '0;
      index  = '0;
      found  = 1'b0;
      j      = '0;
      for (int k = 1; k <= N; k++) begin
         j = IW'((int'(last_grant) + k) % N);
         if (!found && req[j]) begin
            found     = 1'b1;
            winner[j] = 1'b1;
            index     = j;
         end
      end
   end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter and access sequencer for one shared 16-word bank.
// Latches the winner's command, holds it for a fixed access, returns done.
module mem_bank_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ADDR_WIDTH    = BANK_ADDR_WIDTH,
   parameter int DATA_WIDTH    = 32,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic [ADDR_WIDTH-1:0]         mem_address,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata
);

   localparam int IW = idx_width(NUM_REQ);
   localparam logic [CNT_WIDTH-1:0] CNT_INIT  = CNT_WIDTH'(ACCESS_CYCLES - 1);
   localparam logic [IW-1:0]        LAST_INIT = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0]   ONE       = NUM_REQ'(1);

   state_t                 state;
   logic [IW-1:0]          last_grant;
   logic [CNT_WIDTH-1:0]   count;

   logic [NUM_REQ-1:0]     pick_onehot;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;

   logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req        (req),
      .last_grant (last_grant),
      .winner     (pick_onehot),
      .index      (pick_idx),
      .any_req    (pick_any)
   );

   // Sequencer: grant and latch in IDLE, hold the bank for the access, pulse done.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= LAST_INIT;
         count       <= '0;
         grant       <= '0;
         done        <= '0;
         rdata       <= '0;
         mem_address <= '0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  grant       <= pick_onehot;
                  last_grant  <= pick_idx;
                  mem_address <= addr_arr[pick_idx];
                  mem_we      <= req_we[pick_idx];
                  mem_wdata   <= wdata_arr[pick_idx];
                  mem_en      <= 1'b1;
                  count       <= CNT_INIT;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               grant <= '0;
               if (count == '0) begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (!mem_we) begin
                     rdata <= mem_rdata;
                  end
                  done  <= ONE << last_grant;
                  state <= RESP;
               end else begin
                  count <= count - 1'b1;
               end
            end
            RESP: begin
               done  <= '0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
